// File: rtl/lamp_seq_monitor.sv
// lamp_seq_monitor: watches three lamp lines that should sweep 000 -> 100 -> 110 -> 111 -> 000.
// Flags out-of-order patterns and counts completed sweeps.
// All outputs are registered, so each pulse appears in the cycle after the edge that sampled its cause.
// Optional feature: define LAMP_SEQ_MON_ERRCNT_EN to build a saturating 8-bit error counter on err_cnt.
// Without it, err_cnt reads constant zero and no counter is built.
`timescale 1ns/1ps

module lamp_seq_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             clr,
    output logic             start,
    output logic             done,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] sweep_cnt,
    output logic [2:0]       state,
    output logic [7:0]       err_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S1     = 3'd1,
        S2     = 3'd2,
        S3     = 3'd3,
        RESYNC = 3'd4
    } monState_e;

    localparam logic [2:0] PAT_OFF   = 3'b000;
    localparam logic [2:0] PAT_ONE   = 3'b100;
    localparam logic [2:0] PAT_TWO   = 3'b110;
    localparam logic [2:0] PAT_THREE = 3'b111;

    monState_e        state_q, state_d;
    logic [2:0]       prev_q;
    logic [2:0]       sample;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             errSticky_q, errSticky_d;
    logic [CNT_W-1:0] sweepCnt_q, sweepCnt_d;
    logic [2:0]       statePattern;
    logic             inOrder;

    assign sample = {a, b, c};

    // Lamp pattern implied by each tracking state; the previous sample must match it for a step to count.
    always_comb begin
        statePattern = PAT_OFF;
        case (state_q)
            IDLE:    statePattern = PAT_OFF;
            S1:      statePattern = PAT_ONE;
            S2:      statePattern = PAT_TWO;
            S3:      statePattern = PAT_THREE;
            default: statePattern = PAT_OFF;
        endcase
    end

    assign inOrder = (prev_q == statePattern);

    // Next-state logic: one legal successor per tracking state, anything else drops into RESYNC with an error.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (inOrder && sample == PAT_OFF) begin
                    state_d = IDLE;
                end else if (inOrder && sample == PAT_ONE) begin
                    state_d = S1;
                    start_d = 1'b1;
                end else begin
                    state_d = RESYNC;
                    err_d   = 1'b1;
                end
            end
            S1: begin
                if (inOrder && sample == PAT_TWO) begin
                    state_d = S2;
                end else begin
                    state_d = RESYNC;
                    err_d   = 1'b1;
                end
            end
            S2: begin
                if (inOrder && sample == PAT_THREE) begin
                    state_d = S3;
                end else begin
                    state_d = RESYNC;
                    err_d   = 1'b1;
                end
            end
            S3: begin
                if (inOrder && sample == PAT_OFF) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RESYNC;
                    err_d   = 1'b1;
                end
            end
            RESYNC: begin
                if (sample == PAT_OFF) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RESYNC;
            end
        endcase
    end

    // Sticky flag and sweep counter: a fresh error beats clr, while clr beats a sweep increment.
    always_comb begin
        errSticky_d = errSticky_q;
        sweepCnt_d  = sweepCnt_q;
        if (err_d) begin
            errSticky_d = 1'b1;
        end else if (clr) begin
            errSticky_d = 1'b0;
        end
        if (clr) begin
            sweepCnt_d = '0;
        end else if (done_d) begin
            sweepCnt_d = sweepCnt_q + 1'b1;
        end
    end

    // State, previous sample and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prev_q      <= PAT_OFF;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            errSticky_q <= 1'b0;
            sweepCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= sample;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            errSticky_q <= errSticky_d;
            sweepCnt_q  <= sweepCnt_d;
        end
    end

`ifdef LAMP_SEQ_MON_ERRCNT_EN
    logic [7:0] errCnt_q, errCnt_d;

    // Saturating error counter; clr restarts it, and an error in the same cycle counts as the first one.
    always_comb begin
        errCnt_d = errCnt_q;
        if (clr) begin
            errCnt_d = err_d ? 8'd1 : 8'd0;
        end else if (err_d && errCnt_q != 8'hFF) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            errCnt_q <= 8'd0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign start      = start_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_sticky = errSticky_q;
    assign sweep_cnt  = sweepCnt_q;
    assign state      = state_q;

endmodule
